rename_alloc_ctrl: RTL
======================

# rename_alloc_ctrl

Allocation controller for the ROB and store buffer (SB) feeding the rename stage. It owns the ROB and SB head/tail pointers and occupancy counts. It supplies rename with the next ROB/SB entry indices and a combined ready, and sequences mispredict recovery: it discards every uncommitted ROB/SB entry and holds rename off for a fixed drain window.

## Interface
Parameters:
- ROB_ENTRY, 16: ROB depth; power of two, ≥2.
- SB_ENTRY, 8: SB depth; power of two, ≥2.
- FLUSH_CYCLES, 2: cycles rename is held off after a rollback; ≥1.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- rename_rob_v_i  in  1  rename allocates one ROB entry this cycle.
- rename_sb_v_i  in  1  rename also allocates one SB entry; only valid with rename_rob_v_i.
- commit_v_i  in  1  ROB head commits this cycle.
- commit_is_store_i  in  1  the committing entry is a store.
- mispredict_i  in  1  the committing entry mispredicted. Rollback = commit_v_i & mispredict_i.
- sb_retire_v_i  in  1  SB head (a committed store) has drained to memory.
- rob_ready_o  out  1  ROB and SB both have a free entry and no flush is in progress.
- rob_num_o  out  $clog2(ROB_ENTRY)  index of the next ROB entry to allocate (ROB tail).
- sb_num_o  out  $clog2(SB_ENTRY)  index of the next SB entry to allocate (SB tail).
- rob_count_o  out  $clog2(ROB_ENTRY)+1  live ROB entries.
- sb_count_o  out  $clog2(SB_ENTRY)+1  live SB entries, committed and uncommitted.
- flush_o  out  1  high while in FLUSH.

## Operation
- State: rob_head, rob_tail, rob_count, sb_head, sb_tail, sb_count, sb_cmt (committed but not yet drained stores), FSM {RUN, FLUSH}, flush counter of width $clog2(FLUSH_CYCLES+1).
- rob_ready_o = (state==RUN) & (rob_count!=ROB_ENTRY) & (sb_count!=SB_ENTRY). It is combinational from registers only.
- Allocation, accepted only when rob_ready_o=1 and there is no rollback:
  - rename_rob_v_i → rob_tail+1, rob_count+1.
  - rename_sb_v_i → sb_tail+1, sb_count+1.
  - rename_rob_v_i or rename_sb_v_i while rob_ready_o=0 is ignored.
- Commit without mispredict:
  - rob_head+1, rob_count−1.
  - If commit_is_store_i: sb_cmt+1.
  - A commit while rob_count=0 is ignored.
- SB drain: sb_retire_v_i with sb_cmt>0 → sb_head+1, sb_count−1, sb_cmt−1. With sb_cmt=0 it is ignored.
- Simultaneous events:
  - Allocation and commit in the same cycle: the count is unchanged and both pointers advance.
  - Allocation, commit of a store, and SB drain in the same cycle: each counter gets the net sum.
- Rollback cycle:
  - ROB: rob_head_n = rob_head+1 (the branch retires), rob_tail_n = rob_head_n, rob_count_n = 0.
  - SB: first apply the drain (sb_head_n, sb_cmt_n). Then sb_tail_n = sb_head_n + sb_cmt_n and sb_count_n = sb_cmt_n.
  - Any allocation in this cycle is discarded.
  - FSM → FLUSH with counter = FLUSH_CYCLES.
- FSM:
  - RUN → FLUSH on rollback.
  - In FLUSH the counter decrements each cycle. Moving to RUN occurs on the cycle the counter goes 1→0.
  - A rollback seen in FLUSH reloads the counter; state stays FLUSH.
  - SB drain continues in FLUSH.
- Arithmetic:
  - Pointers wrap modulo depth through natural binary overflow.
  - Counts are one bit wider, so the full value is representable.
  - tail == head with count == depth means full; with count == 0 it means empty.
- flush_o = (state==FLUSH).

## Timing
- Reset (reset_n_i low, asynchronous): all pointers, counts, sb_cmt and the flush counter go to 0; state goes to RUN.
  - Outputs during reset: rob_ready_o=1, rob_num_o=0, sb_num_o=0, counts 0, flush_o=0.
  - Release is synchronous to clk_i through the normal flop path.
  - A reset mid-FLUSH returns directly to RUN.
- Allocation accepted in cycle N → rob_num_o, sb_num_o and the counts reflect it in N+1. Rename samples rob_num_o/sb_num_o in cycle N as the allocated index.
- Full: a count reaching depth in N+1 drops rob_ready_o in N+1. One free entry (from a commit or drain) raises it in the following cycle.
- Rollback in cycle N:
  - flush_o=1 and rob_ready_o=0 in N+1 … N+FLUSH_CYCLES.
  - RUN and rob_ready_o=1 in N+FLUSH_CYCLES+1, provided the SB is not full.
  - rob_num_o = the new head from N+1.

## Test plan
- Reset, then 16 back-to-back allocations with no commits → rob_num_o counts 0..15. rob_ready_o=0 from cycle 17 with rob_count_o=16. One commit → ready=1 the next cycle and rob_num_o=0 (wrap).
- Allocate 8 stores with no commits → sb_count_o=8 and rob_ready_o=0 while rob_count_o=8. Commit 1 store and pulse sb_retire_v_i → sb_count_o=7, then ready=1.
- Allocate 5 entries (3 stores), commit 2 stores, then assert rollback with sb_retire_v_i=1 in the same cycle → next cycle: rob_count_o=0, sb_count_o=1, sb_num_o=2. flush_o is high for 2 cycles and ready returns on the 3rd.
- Allocation and commit in the same cycle at rob_count_o=4 → count stays 4, rob_num_o+1.
- Rollback during the cycle that rename_rob_v_i=1 → allocation discarded, rob_count_o=0. A second rollback in FLUSH extends flush_o by FLUSH_CYCLES from that cycle.
- Assert reset_n_i low asynchronously mid-FLUSH with counts nonzero → all outputs reach their reset values before the next edge; RUN after release.

Source files
------------

// File: rtl/rename_alloc_ctrl.sv
// ROB / store-buffer allocation controller for rename.
// Owns head/tail/count state and sequences mispredict recovery.
module rename_alloc_ctrl #(
   parameter int ROB_ENTRY    = 16,
   parameter int SB_ENTRY     = 8,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          rename_rob_v_i,
   input  logic                          rename_sb_v_i,
   input  logic                          commit_v_i,
   input  logic                          commit_is_store_i,
   input  logic                          mispredict_i,
   input  logic                          sb_retire_v_i,
   output logic                          rob_ready_o,
   output logic [$clog2(ROB_ENTRY)-1:0]  rob_num_o,
   output logic [$clog2(SB_ENTRY)-1:0]   sb_num_o,
   output logic [$clog2(ROB_ENTRY):0]    rob_count_o,
   output logic [$clog2(SB_ENTRY):0]     sb_count_o,
   output logic                          flush_o
);

   localparam int RW = $clog2(ROB_ENTRY);
   localparam int SW = $clog2(SB_ENTRY);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [RW:0]   ROB_FULL = (RW + 1)'(ROB_ENTRY);
   localparam logic [SW:0]   SB_FULL  = (SW + 1)'(SB_ENTRY);
   localparam logic [FW-1:0] F_LOAD   = FW'(FLUSH_CYCLES);
   localparam logic [FW-1:0] F_ONE    = FW'(1);

   typedef enum logic {RUN, FLUSH} state_e;

   state_e        state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [RW-1:0] rob_head_q, rob_head_d;
   logic [RW-1:0] rob_tail_q, rob_tail_d;
   logic [RW:0]   rob_count_q, rob_count_d;
   logic [SW-1:0] sb_head_q, sb_head_d;
   logic [SW-1:0] sb_tail_q, sb_tail_d;
   logic [SW:0]   sb_count_q, sb_count_d;
   logic [SW:0]   sb_cmt_q, sb_cmt_d;

   logic rollback, commit, drain, rob_alloc, sb_alloc;

   assign rob_ready_o = (state_q == RUN) & (rob_count_q != ROB_FULL)
                        & (sb_count_q != SB_FULL);

   assign rollback  = commit_v_i & mispredict_i;
   assign commit    = commit_v_i & ~mispredict_i & (rob_count_q != '0);
   assign drain     = sb_retire_v_i & (sb_cmt_q != '0);
   assign rob_alloc = rob_ready_o & rename_rob_v_i & ~rollback;
   assign sb_alloc  = rob_alloc & rename_sb_v_i;

   always_comb begin
      rob_head_d  = rob_head_q + RW'(commit | rollback);
      rob_tail_d  = rob_tail_q + RW'(rob_alloc);
      rob_count_d = rob_count_q + (RW + 1)'(rob_alloc) - (RW + 1)'(commit);
      sb_head_d   = sb_head_q + SW'(drain);
      sb_cmt_d    = sb_cmt_q + (SW + 1)'(commit & commit_is_store_i)
                    - (SW + 1)'(drain);
      sb_tail_d   = sb_tail_q + SW'(sb_alloc);
      sb_count_d  = sb_count_q + (SW + 1)'(sb_alloc) - (SW + 1)'(drain);
      // Recovery keeps only committed stores; everything younger is dropped.
      if (rollback) begin
         rob_tail_d  = rob_head_d;
         rob_count_d = '0;
         sb_tail_d   = sb_head_d + sb_cmt_d[SW-1:0];
         sb_count_d  = sb_cmt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         RUN: begin
            if (rollback) begin
               state_d = FLUSH;
               fcnt_d  = F_LOAD;
            end
         end
         FLUSH: begin
            if (rollback) begin
               fcnt_d = F_LOAD;
            end else begin
               fcnt_d = fcnt_q - F_ONE;
               if (fcnt_q == F_ONE) state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= RUN;
         fcnt_q      <= '0;
         rob_head_q  <= '0;
         rob_tail_q  <= '0;
         rob_count_q <= '0;
         sb_head_q   <= '0;
         sb_tail_q   <= '0;
         sb_count_q  <= '0;
         sb_cmt_q    <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         rob_head_q  <= rob_head_d;
         rob_tail_q  <= rob_tail_d;
         rob_count_q <= rob_count_d;
         sb_head_q   <= sb_head_d;
         sb_tail_q   <= sb_tail_d;
         sb_count_q  <= sb_count_d;
         sb_cmt_q    <= sb_cmt_d;
      end
   end

   assign rob_num_o   = rob_tail_q;
   assign sb_num_o    = sb_tail_q;
   assign rob_count_o = rob_count_q;
   assign sb_count_o  = sb_count_q;
   assign flush_o     = (state_q == FLUSH);

endmodule
